pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
//  Generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a wide data payload plus a control payload. The control payload is forced to a bubble (NOP) value whenever the stage is empty or flushed.
//  in_ready is fully registered, so back-pressure does not form a combinational ready chain across stages.
// PARAMETERS
//  DATA_W      160  width of data payload (PCs, operands, immediate, reg indices)
//  CTRL_W      16   width of control payload (regWrite, memWrite, resultSrc, ...)
//  CTRL_BUBBLE '0   control value presented when out_valid=0; must encode a NOP
//  SKID_EN     1    1: 2-entry skid buffer with registered in_ready; 0: single slot, in_ready = out_ready | ~out_valid
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       upstream beat valid
//  in_ready   out  1       stage can accept a beat this cycle
//  in_data    in   DATA_W  upstream data payload
//  in_ctrl    in   CTRL_W  upstream control payload
//  flush      in   1       squash all held beats and any beat offered this cycle
//  out_valid  out  1       downstream beat valid
//  out_ready  in   1       downstream accepts beat (low = stall)
//  out_data   out  DATA_W  data payload of head beat
//  out_ctrl   out  CTRL_W  control of head beat; CTRL_BUBBLE when out_valid=0
//  occupancy  out  2       number of held beats (0..2)
// BEHAVIOUR
//  Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
//  Priority: rst_n, then flush, then handshake.
//  Reset (async assert, sync deassert from the system reset tree) produces:
//   out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0, skid cleared.
//   in_ready=1 from the first clock edge after deassertion.
//  Slots: MAIN drives the outputs directly. SKID holds the overflow beat.
//  States and transitions (SKID_EN=1):
//   EMPTY: push -> ONE (MAIN<=in).
//   ONE:   push&pop -> ONE (MAIN<=in).
//          push&~pop -> TWO (SKID<=in).
//          pop&~push -> EMPTY (MAIN.ctrl<=CTRL_BUBBLE).
//   TWO:   in_ready=0.
//          pop -> ONE (MAIN<=SKID, SKID.ctrl<=CTRL_BUBBLE).
//  in_ready = (state != TWO), registered. No combinational path from out_ready to in_ready.
//  SKID_EN=0: states EMPTY/ONE only; in_ready = out_ready | ~out_valid (combinational).
//  Latency: a push reaches out_* on the next cycle when the stage is empty; throughput is 1 beat/cycle.
//  Stall (out_ready=0) holds out_* stable: data, ctrl and valid must not change while out_valid=1 & ~out_ready.
//  Flush: next cycle the stage is EMPTY.
//   out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0.
//   A beat pushed in the flush cycle is dropped.
//   A pop in the flush cycle still completes downstream.
//   Data regs may hold stale values (don't-care while invalid).
//  Flush while in TWO: both beats are discarded and in_ready returns to 1 next cycle.
//  Reset asserted mid-transfer: all beats are lost immediately (async). No partial state survives.
//  Order is strictly FIFO: a beat never overtakes one already held.
//  Never duplicated, never lost, except by flush or reset.
//  Assertions: out_ctrl==CTRL_BUBBLE whenever ~out_valid; occupancy<=2; ~in_ready -> occupancy==2.
// STRUCTURE
//  pipe_pkg: occupancy state enum (EMPTY/ONE/TWO) and default NOP control constant.
//   Per-stage packed control structs also live here; CTRL_W is derived from $bits(struct).
//  Sub-module pipe_slot: one {valid, data, ctrl} register with load/clear/bubble inputs.
//   Instantiated twice (MAIN, SKID).
//  Top level holds the state register, handshake logic, and slot load/select muxing.
// TESTING
//  1. Reset with rst_n=0 mid-stream, holding 2 beats -> immediately out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0; in_ready=1 after release.
//  2. Streaming: in_valid=1 every cycle with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, occupancy=1 steady.
//  3. Back-pressure: push A,B with out_ready=0 -> in_ready=0 after B, occupancy=2, out_data=A stable.
//     Then raise out_ready -> A, then B, with no loss.
//  4. Flush in TWO with simultaneous in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0; C never emerges.
//  5. Random valid/ready (10k cycles, 30% flush-free windows) vs scoreboard -> exact FIFO order, ctrl bubble when invalid; repeat with SKID_EN=0.
//  6. Pop in the same cycle as flush with occupancy=1 -> beat counted delivered; next cycle empty.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the pipeline stage register: occupancy state encoding and
// the packed per-stage control word whose all-zero value is the NOP bubble.
package pipe_skid_stage_pkg;

    // Encoded so that the state value equals the number of held beats.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] imm_src;
        logic [1:0] rsvd;
    } ex_ctrl_t;

    localparam int       CTRL_W_DEF = $bits(ex_ctrl_t);
    localparam ex_ctrl_t CTRL_NOP   = '0;

    function automatic logic [1:0] occ_of(input occ_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// One {valid, data, ctrl} holding register. Clearing drops the beat and
// parks ctrl at the bubble value; data is left stale on purpose.
module pipe_skid_stage_slot
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W      = 160,
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            ctrl_q  <= ctrl_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Handshake: a beat moves when valid & ready are both high at a rising edge.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W      = 160,
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
    parameter bit                SKID_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [1:0]        state_dbg
);

    occ_state_e state_q, state_d;
    logic       in_ready_q;
    logic       push, pop;

    logic              main_load, main_from_skid, main_clear;
    logic              skid_load, skid_clear;
    logic [DATA_W-1:0] main_din;
    logic [CTRL_W-1:0] main_cin;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            // A pop this cycle still completes downstream; everything held or offered is dropped.
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // With the skid buffer, ready comes straight from a flop so stalls never chain combinationally.
    assign in_ready = SKID_EN ? in_ready_q : (out_ready | ~out_valid);

    assign main_din = main_from_skid ? skid_data : in_data;
    assign main_cin = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_skid_stage_slot #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_din),
        .ctrl_i  (main_cin),
        .valid_o (out_valid),
        .data_o  (out_data),
        .ctrl_o  (out_ctrl)
    );

    pipe_skid_stage_slot #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    assign occupancy = occ_of(state_q);
    assign state_dbg = state_q;

    a_bubble: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> out_ctrl == CTRL_BUBBLE);
    a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= 2'd2);
    a_ready_full: assert property (@(posedge clk) disable iff (!rst_n)
        (SKID_EN && !in_ready) |-> occupancy == 2'd2);
    a_skid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_TWO) |-> skid_valid);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: the same stimulus drives a skid (SKID_EN=1) and a
// single-slot (SKID_EN=0) instance, each with its own held-beat queue model.
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam int          DW  = 160;
    localparam int          CW  = CTRL_W_DEF;
    localparam logic [CW-1:0] BUB = 16'h0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_ready;

    logic          ir  [2];
    logic          ov  [2];
    logic [DW-1:0] od  [2];
    logic [CW-1:0] oc  [2];
    logic [1:0]    occ [2];
    logic [1:0]    st  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int seq      = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    endtask

    // Hidden holding capacity: 2 beats with skid, 1 without.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit SK = (g == 0);

        pipe_skid_stage #(
            .DATA_W      (DW),
            .CTRL_W      (CW),
            .CTRL_BUBBLE (BUB),
            .SKID_EN     (SK)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .in_ctrl   (in_ctrl),
            .flush     (flush),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .out_ctrl  (oc[g]),
            .occupancy (occ[g]),
            .state_dbg (st[g])
        );

        logic [DW+CW-1:0] exp_q[$];

        always begin : monitor
            logic exp_ready;
            @(negedge clk);
            #1;
            if (rst_n) begin
                exp_ready = SK ? (exp_q.size() < 2) : (out_ready || exp_q.size() == 0);
                chk("occupancy", g, 192'(occ[g]), 192'(exp_q.size()));
                chk("out_valid", g, 192'(ov[g]), 192'(exp_q.size() != 0));
                chk("in_ready", g, 192'(ir[g]), 192'(exp_ready));
                if (exp_q.size() == 0) begin
                    chk("ctrl_bubble", g, 192'(oc[g]), 192'(BUB));
                end else begin
                    chk("head_beat", g, 192'({od[g], oc[g]}), 192'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end

        always begin : sb_push
            @(negedge clk);
            #2;
            if (!rst_n || flush) exp_q.delete();
            else if (in_valid && ir[g]) exp_q.push_back({in_data, in_ctrl});
        end
    end

    task automatic cyc(input bit iv, input bit ordy, input bit fl);
        logic [CW-1:0] c;
        @(negedge clk);
        seq++;
        c = CW'($urandom_range(1, 65535));
        if (c == BUB) c = ~BUB;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = {$urandom, $urandom, $urandom, $urandom, 32'(seq)};
        in_ctrl   = c;
    endtask

    initial begin
        bit fl_en;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_data = '0; in_ctrl = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", d, 192'(ov[d]), 192'(0));
            chk("reset_occ", d, 192'(occ[d]), 192'(0));
            chk("reset_ctrl", d, 192'(oc[d]), 192'(BUB));
            chk("reset_data", d, 192'(od[d]), 192'(0));
        end
        #3 rst_n = 1'b1;

        // Streaming 1..8 at full rate.
        seq = 0;
        repeat (8) cyc(1, 1, 0);
        repeat (2) cyc(0, 1, 0);

        // Back-pressure: A, B held, C refused, then drain.
        repeat (3) cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);

        // Flush while full with a new beat offered.
        repeat (2) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (2) cyc(0, 1, 0);

        // Pop in the same cycle as flush.
        cyc(1, 0, 0);
        cyc(0, 1, 1);
        repeat (2) cyc(0, 1, 0);

        // Reset mid-stream while holding beats.
        repeat (2) cyc(1, 0, 0);
        cyc(0, 0, 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_valid", d, 192'(ov[d]), 192'(0));
            chk("async_rst_occ", d, 192'(occ[d]), 192'(0));
            chk("async_rst_ctrl", d, 192'(oc[d]), 192'(BUB));
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("ready_after_rst", d, 192'(ir[d]), 192'(1));

        // Random traffic in windows; some windows never flush.
        for (int w = 0; w < 200; w++) begin
            fl_en = ($urandom_range(0, 9) >= 3);
            repeat (50) cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                            fl_en && ($urandom_range(0, 19) == 0));
        end
        repeat (4) cyc(0, 1, 0);
        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
